// File: rtl/mmio_responder_pkg.sv
// Shared constants for the MMIO responder: register offsets, DMType access
// size encodings, CTRL bit positions and the byte-lane merge helper.
// The timer block is built only when MMIO_TIMER_EN is defined.
package mmio_pkg;

    // Register offsets inside the 256-byte window
    localparam logic [7:0] OFF_SW   = 8'h00;
    localparam logic [7:0] OFF_DISP = 8'h04;
    localparam logic [7:0] OFF_CNT  = 8'h08;
    localparam logic [7:0] OFF_CMP  = 8'h0C;
    localparam logic [7:0] OFF_CTRL = 8'h10;

    // DMType access size encodings
    localparam logic [2:0] DM_WORD  = 3'b000;
    localparam logic [2:0] DM_HALF  = 3'b001;
    localparam logic [2:0] DM_HALFU = 3'b010;
    localparam logic [2:0] DM_BYTE  = 3'b011;
    localparam logic [2:0] DM_BYTEU = 3'b100;

    // CTRL bit positions
    localparam int CTRL_EN         = 0;
    localparam int CTRL_AUTORELOAD = 1;
    localparam int CTRL_IRQ_EN     = 2;
    localparam int CTRL_FLAG       = 8;

    // Replace the byte lanes selected by be with the lanes of nxt
    function automatic logic [31:0] merge_lanes(input logic [31:0] cur,
                                                input logic [31:0] nxt,
                                                input logic [3:0]  be);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = be[i] ? nxt[8*i +: 8] : cur[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/mmio_responder_if.sv
// CPU-side memory bus for the MMIO responder (EX/MEM stage signals).
// Handshake: there is no valid/ready pair. A store is accepted at the
// posedge where MemWrite && hit_o; a load is answered combinationally on
// dout in the same cycle MemRead is high, and dout is 0 otherwise.
interface mmio_responder_if;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] addr;
    logic [31:0] din;
    logic [2:0]  DMType;
    logic        hit_o;
    logic [31:0] dout;

    modport master (
        output MemWrite, MemRead, addr, din, DMType,
        input  hit_o, dout
    );

    modport slave (
        input  MemWrite, MemRead, addr, din, DMType,
        output hit_o, dout
    );
endinterface

// File: rtl/mmio_responder_timer.sv
// Free-running compare timer: CNT, CMP, CTRL and the match flag.
// Write data arrives already lane-merged from the top. Only instantiated
// when MMIO_TIMER_EN is defined.
module mmio_timer
    import mmio_pkg::*;
(
    input  logic        Clk_CPU,
    input  logic        rstn,
    input  logic        wr_cnt,
    input  logic        wr_cmp,
    input  logic        wr_ctrl,
    input  logic [31:0] cnt_wdata,
    input  logic [31:0] cmp_wdata,
    input  logic [2:0]  ctrl_wdata,
    input  logic        flag_clr,
    output logic [31:0] cnt,
    output logic [31:0] cmp,
    output logic [31:0] ctrl_rd,
    output logic        irq
);

    logic [2:0] ctrl;
    logic       flag;
    logic       match;

    assign match   = ctrl[CTRL_EN] && (cnt == cmp);
    assign ctrl_rd = {23'b0, flag, 5'b0, ctrl};
    assign irq     = flag && ctrl[CTRL_IRQ_EN];

    // Counter: CPU write beats autoreload, which beats increment
    always_ff @(posedge Clk_CPU or negedge rstn) begin
        if (!rstn) begin
            cnt <= 32'h0;
        end else if (wr_cnt) begin
            cnt <= cnt_wdata;
        end else if (ctrl[CTRL_EN]) begin
            if (match && ctrl[CTRL_AUTORELOAD]) begin
                cnt <= 32'h0;
            end else begin
                cnt <= cnt + 32'd1;
            end
        end
    end

    // Compare value and control bits
    always_ff @(posedge Clk_CPU or negedge rstn) begin
        if (!rstn) begin
            cmp  <= 32'hFFFF_FFFF;
            ctrl <= 3'b000;
        end else begin
            if (wr_cmp)  cmp  <= cmp_wdata;
            if (wr_ctrl) ctrl <= ctrl_wdata;
        end
    end

    // Match flag: a new match wins over a simultaneous write-1-clear
    always_ff @(posedge Clk_CPU or negedge rstn) begin
        if (!rstn) begin
            flag <= 1'b0;
        end else if (match) begin
            flag <= 1'b1;
        end else if (flag_clr) begin
            flag <= 1'b0;
        end
    end

endmodule

// File: rtl/mmio_responder.sv
// MMIO responder: switch input, seven-segment DISP register and an optional
// compare timer behind a 256-byte window at BASE_ADDR. Handles byte/half/word
// lane merging on stores and lane extraction with sign/zero extension on
// loads. Define MMIO_TIMER_EN to build the timer (CNT/CMP/CTRL, irq_o).
module mmio_responder
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000
) (
    input  logic              Clk_CPU,
    input  logic              rstn,
    mmio_responder_if.slave   bus,
    input  logic [15:0]       sw_i,
    output logic [31:0]       disp_data_o,
    output logic              irq_o
);

    logic [15:0] sw_s1;
    logic [15:0] sw_s2;
    logic [31:0] disp;
    logic [7:0]  word_off;
    logic [3:0]  be;
    logic        access_ok;
    logic [31:0] wlane;
    logic        wr_en;
    logic [31:0] rword;
    logic [31:0] shifted;
    logic [31:0] ext;

    assign bus.hit_o   = (bus.addr[31:8] == BASE_ADDR[31:8]);
    assign word_off    = {bus.addr[7:2], 2'b00};
    assign wr_en       = bus.MemWrite && bus.hit_o && access_ok;
    assign disp_data_o = disp;

    // Byte enables and alignment check; unknown DMType codes are rejected
    always_comb begin
        be        = 4'b0000;
        access_ok = 1'b0;
        case (bus.DMType)
            DM_WORD: begin
                be        = 4'b1111;
                access_ok = (bus.addr[1:0] == 2'b00);
            end
            DM_HALF, DM_HALFU: begin
                be        = bus.addr[1] ? 4'b1100 : 4'b0011;
                access_ok = !bus.addr[0];
            end
            DM_BYTE, DM_BYTEU: begin
                be        = 4'b0001 << bus.addr[1:0];
                access_ok = 1'b1;
            end
            default: begin
                be        = 4'b0000;
                access_ok = 1'b0;
            end
        endcase
    end

    // Replicate low-aligned store data into every lane it may land in
    always_comb begin
        wlane = bus.din;
        case (bus.DMType)
            DM_HALF, DM_HALFU: wlane = {2{bus.din[15:0]}};
            DM_BYTE, DM_BYTEU: wlane = {4{bus.din[7:0]}};
            default:           wlane = bus.din;
        endcase
    end

    // Two-flop synchronizer for the board switches
    always_ff @(posedge Clk_CPU or negedge rstn) begin
        if (!rstn) begin
            sw_s1 <= 16'h0;
            sw_s2 <= 16'h0;
        end else begin
            sw_s1 <= sw_i;
            sw_s2 <= sw_s1;
        end
    end

    // DISP register with lane-merged stores
    always_ff @(posedge Clk_CPU or negedge rstn) begin
        if (!rstn) begin
            disp <= 32'h0;
        end else if (wr_en && (word_off == OFF_DISP)) begin
            disp <= merge_lanes(disp, wlane, be);
        end
    end

`ifdef MMIO_TIMER_EN
    logic [31:0] cnt;
    logic [31:0] cmp;
    logic [31:0] ctrl_rd;
    logic [31:0] ctrl_merged;
    logic        timer_irq;

    // Only the low CTRL bits are stored; the flag lane is write-1-clear
    assign ctrl_merged = merge_lanes(ctrl_rd, wlane, be);

    mmio_timer u_timer (
        .Clk_CPU    (Clk_CPU),
        .rstn       (rstn),
        .wr_cnt     (wr_en && (word_off == OFF_CNT)),
        .wr_cmp     (wr_en && (word_off == OFF_CMP)),
        .wr_ctrl    (wr_en && (word_off == OFF_CTRL)),
        .cnt_wdata  (merge_lanes(cnt, wlane, be)),
        .cmp_wdata  (merge_lanes(cmp, wlane, be)),
        .ctrl_wdata (ctrl_merged[2:0]),
        .flag_clr   (wr_en && (word_off == OFF_CTRL) && be[1] && wlane[CTRL_FLAG]),
        .cnt        (cnt),
        .cmp        (cmp),
        .ctrl_rd    (ctrl_rd),
        .irq        (timer_irq)
    );

    assign irq_o = timer_irq;
`else
    assign irq_o = 1'b0;
`endif

    // Read mux over the register map; holes read 0
    always_comb begin
        rword = 32'h0;
        case (word_off)
            OFF_SW:   rword = {16'b0, sw_s2};
            OFF_DISP: rword = disp;
`ifdef MMIO_TIMER_EN
            OFF_CNT:  rword = cnt;
            OFF_CMP:  rword = cmp;
            OFF_CTRL: rword = ctrl_rd;
`endif
            default:  rword = 32'h0;
        endcase
    end

    assign shifted = rword >> {bus.addr[1:0], 3'b000};

    // Lane extraction with sign or zero extension
    always_comb begin
        ext = 32'h0;
        case (bus.DMType)
            DM_WORD:  ext = shifted;
            DM_HALF:  ext = {{16{shifted[15]}}, shifted[15:0]};
            DM_HALFU: ext = {16'b0, shifted[15:0]};
            DM_BYTE:  ext = {{24{shifted[7]}}, shifted[7:0]};
            DM_BYTEU: ext = {24'b0, shifted[7:0]};
            default:  ext = 32'h0;
        endcase
    end

    assign bus.dout = (bus.MemRead && bus.hit_o && access_ok) ? ext : 32'h0;

endmodule

// File: tb/tb_mmio_responder.sv
// Directed bench for mmio_responder: switch sync latency, DISP lane merge
// and load extension, misaligned/miss handling, timer (when MMIO_TIMER_EN is
// defined) or its absence, and asynchronous reset.
module tb_mmio_responder;
    import mmio_pkg::*;

    localparam logic [31:0] BASE = 32'hFFFF_0000;

    logic        Clk_CPU = 1'b0;
    logic        rstn    = 1'b0;
    logic [15:0] sw_i    = 16'h0;
    logic [31:0] disp_data_o;
    logic        irq_o;

    int n_checks = 0;
    int n_errors = 0;

    mmio_responder_if bus();

    mmio_responder #(.BASE_ADDR(BASE)) dut (
        .Clk_CPU     (Clk_CPU),
        .rstn        (rstn),
        .bus         (bus),
        .sw_i        (sw_i),
        .disp_data_o (disp_data_o),
        .irq_o       (irq_o)
    );

    // Clock and watchdog
    always #5 Clk_CPU = ~Clk_CPU;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Driver tasks: called at a negedge, return at the following negedge
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [2:0] dm);
        bus.addr     = a;
        bus.din      = d;
        bus.DMType   = dm;
        bus.MemWrite = 1'b1;
        @(negedge Clk_CPU);
        bus.MemWrite = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [31:0] a, input logic [2:0] dm,
                            input logic [31:0] exp);
        bus.addr    = a;
        bus.DMType  = dm;
        bus.MemRead = 1'b1;
        #1;
        check(tag, bus.dout, exp);
        bus.MemRead = 1'b0;
        @(negedge Clk_CPU);
    endtask

    logic [31:0] exp_cnt [6] = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0, 32'd1};
    logic        exp_irq [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        bus.MemWrite = 1'b0;
        bus.MemRead  = 1'b0;
        bus.addr     = 32'h0;
        bus.din      = 32'h0;
        bus.DMType   = DM_WORD;

        // Reset state
        #12;
        check("rst_disp", disp_data_o, 32'h0);
        check("rst_irq", {31'b0, irq_o}, 32'h0);
        bus.addr = BASE; bus.MemRead = 1'b1;
        #1;
        check("rst_sw_read", bus.dout, 32'h0);
        bus.MemRead = 1'b0;
        @(negedge Clk_CPU);
        rstn = 1'b1;

        // Switch synchronizer latency
        sw_i = 16'hA5C3;
        @(negedge Clk_CPU);
        rd_check("sw_1cycle", BASE, DM_WORD, 32'h0);
        rd_check("sw_2cycle", BASE, DM_WORD, 32'h0000_A5C3);

        // DISP lane merge and load extension
        do_write(BASE + 32'h04, 32'h1234_5678, DM_WORD);
        do_write(BASE + 32'h06, 32'h0000_00EE, DM_BYTE);
        check("disp_sb", disp_data_o, 32'h12EE_5678);
        rd_check("lb_06", BASE + 32'h06, DM_BYTE, 32'hFFFF_FFEE);
        rd_check("lbu_06", BASE + 32'h06, DM_BYTEU, 32'h0000_00EE);
        rd_check("lw_04", BASE + 32'h04, DM_WORD, 32'h12EE_5678);
        rd_check("lhu_04", BASE + 32'h04, DM_HALFU, 32'h0000_5678);
        do_write(BASE + 32'h06, 32'h0000_8001, DM_HALF);
        check("disp_sh", disp_data_o, 32'h8001_5678);
        rd_check("lh_06", BASE + 32'h06, DM_HALF, 32'hFFFF_8001);
        rd_check("lhu_06", BASE + 32'h06, DM_HALFU, 32'h0000_8001);
        rd_check("lb_07", BASE + 32'h07, DM_BYTE, 32'hFFFF_FF80);
        rd_check("lbu_04", BASE + 32'h04, DM_BYTEU, 32'h0000_0078);

        // Misaligned, miss, read-only and unmapped accesses
        do_write(BASE + 32'h05, 32'hDEAD_BEEF, DM_WORD);
        check("misalign_sw", disp_data_o, 32'h8001_5678);
        rd_check("misalign_lw", BASE + 32'h05, DM_WORD, 32'h0);
        do_write(BASE + 32'h05, 32'h0000_BEEF, DM_HALF);
        check("misalign_sh", disp_data_o, 32'h8001_5678);
        rd_check("misalign_lh", BASE + 32'h05, DM_HALF, 32'h0);
        bus.addr = 32'hFFFE_0004; bus.din = 32'hDEAD_BEEF; bus.DMType = DM_WORD;
        bus.MemWrite = 1'b1;
        #1;
        check("miss_hit", {31'b0, bus.hit_o}, 32'h0);
        @(negedge Clk_CPU);
        bus.MemWrite = 1'b0;
        check("miss_disp", disp_data_o, 32'h8001_5678);
        bus.MemRead = 1'b1;
        #1;
        check("miss_dout", bus.dout, 32'h0);
        bus.MemRead = 1'b0;
        bus.addr = BASE + 32'h04;
        #1;
        check("hit_base", {31'b0, bus.hit_o}, 32'h1);
        check("noread_dout", bus.dout, 32'h0);
        @(negedge Clk_CPU);
        do_write(BASE, 32'h0, DM_WORD);
        rd_check("sw_ro", BASE, DM_WORD, 32'h0000_A5C3);
        rd_check("unmapped", BASE + 32'h40, DM_WORD, 32'h0);

`ifdef MMIO_TIMER_EN
        // Counting with autoreload and match flag
        do_write(BASE + 32'h0C, 32'd3, DM_WORD);
        do_write(BASE + 32'h08, 32'd0, DM_WORD);
        do_write(BASE + 32'h10, 32'h7, DM_WORD);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("irq_seq%0d", i), {31'b0, irq_o}, {31'b0, exp_irq[i]});
            rd_check($sformatf("cnt_seq%0d", i), BASE + 32'h08, DM_WORD, exp_cnt[i]);
        end
        do_write(BASE + 32'h10, 32'h107, DM_WORD);
        check("clr_irq", {31'b0, irq_o}, 32'h0);
        rd_check("clr_ctrl", BASE + 32'h10, DM_WORD, 32'h0000_0007);

        // Set wins over write-1-clear in the same cycle
        do_write(BASE + 32'h10, 32'h100, DM_WORD);
        check("dis_irq", {31'b0, irq_o}, 32'h0);
        do_write(BASE + 32'h08, 32'd3, DM_WORD);
        do_write(BASE + 32'h10, 32'h7, DM_WORD);
        check("pre_set_irq", {31'b0, irq_o}, 32'h0);
        do_write(BASE + 32'h10, 32'h107, DM_WORD);
        check("set_wins_irq", {31'b0, irq_o}, 32'h1);
        rd_check("set_wins_ctrl", BASE + 32'h10, DM_WORD, 32'h0000_0107);
        rd_check("reload_cnt", BASE + 32'h08, DM_WORD, 32'd1);

        // CPU write beats increment
        do_write(BASE + 32'h10, 32'h5, DM_WORD);
        do_write(BASE + 32'h08, 32'h100, DM_WORD);
        rd_check("cnt_wr_prio", BASE + 32'h08, DM_WORD, 32'h100);
        rd_check("cnt_inc", BASE + 32'h08, DM_WORD, 32'h101);
        do_write(BASE + 32'h0E, 32'h0000_1234, DM_HALF);
        rd_check("cmp_merge", BASE + 32'h0C, DM_WORD, 32'h1234_0003);
        rd_check("cnt_lbu", BASE + 32'h09, DM_BYTEU, 32'h01);
        check("pre_rst_irq", {31'b0, irq_o}, 32'h1);
`else
        // Timer absent
        do_write(BASE + 32'h08, 32'h55, DM_WORD);
        rd_check("notimer_cnt", BASE + 32'h08, DM_WORD, 32'h0);
        do_write(BASE + 32'h10, 32'h7, DM_WORD);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("notimer_irq%0d", i), {31'b0, irq_o}, 32'h0);
            @(negedge Clk_CPU);
        end
        rd_check("notimer_ctrl", BASE + 32'h10, DM_WORD, 32'h0);
        rd_check("notimer_cmp", BASE + 32'h0C, DM_WORD, 32'h0);
`endif

        // Asynchronous reset mid-count
        #2;
        rstn = 1'b0;
        #1;
        check("arst_disp", disp_data_o, 32'h0);
        check("arst_irq", {31'b0, irq_o}, 32'h0);
        bus.addr = BASE; bus.DMType = DM_WORD; bus.MemRead = 1'b1;
        #1;
        check("arst_sw", bus.dout, 32'h0);
        bus.MemRead = 1'b0;
        @(negedge Clk_CPU);
        rstn = 1'b1;
        rd_check("post_rst_disp", BASE + 32'h04, DM_WORD, 32'h0);
`ifdef MMIO_TIMER_EN
        rd_check("post_rst_cnt", BASE + 32'h08, DM_WORD, 32'h0);
        rd_check("post_rst_cmp", BASE + 32'h0C, DM_WORD, 32'hFFFF_FFFF);
        rd_check("post_rst_ctrl", BASE + 32'h10, DM_WORD, 32'h0);
`else
        @(negedge Clk_CPU);
`endif
        rd_check("post_rst_sw", BASE, DM_WORD, 32'h0000_A5C3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
